decode_h2_pipe: RTL and testbench

- Pipelined SECDED decoder for the 16-bit H2 Hamming codeword: 11 data bits plus 5 parity bits.
- Checks the parity bits and corrects any single-bit error. Flags double-bit errors.
- Keeps saturating error statistics.
- Sits on the read path after codeword storage and returns data to the consumer over a valid/ready stream.

---
 rtl/decode_h2_pipe.sv | 166 ++++++++++++++++
 tb/tb_decode_h2_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_h2_pipe.sv
// Two-stage SECDED decoder for the 16-bit H2 codeword {data[10:0], p[4:0]}.
// Stage 1 captures raw data, syndrome and overall parity; stage 2 applies the
// correction and classifies the word. A valid/ready handshake with a single
// advance enable stalls both stages together. Saturating counters tally the
// sec/ded words that are actually handed to the consumer.
module decode_h2_pipe #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          CODE_IN,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [10:0]          DATA_OUT,
  output logic                 sec,
  output logic                 ded,
  output logic [3:0]           syndrome,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] sec_cnt,
  output logic [CNT_WIDTH-1:0] ded_cnt
);

  localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

  logic                 adv;
  logic                 xfer;
  logic [10:0]          code_d;
  logic [4:0]           code_p;
  logic [3:0]           chk_bits;
  logic [10:0]          flip_mask;

  // Stage 1 state
  logic                 v1_q, v1_d;
  logic [10:0]          d1_q, d1_d;
  logic [3:0]           s1_q, s1_d;
  logic                 ov1_q, ov1_d;

  // Stage 2 state (drives the outputs directly)
  logic                 v2_q, v2_d;
  logic [10:0]          data2_q, data2_d;
  logic                 sec2_q, sec2_d;
  logic                 ded2_q, ded2_d;
  logic [3:0]           syn2_q, syn2_d;

  logic [CNT_WIDTH-1:0] sec_cnt_q, sec_cnt_d;
  logic [CNT_WIDTH-1:0] ded_cnt_q, ded_cnt_d;

  // Both stages move together; a held output freezes the whole pipe.
  assign adv      = !v2_q || out_ready;
  assign xfer     = v2_q && out_ready;
  assign in_ready = adv;

  assign code_d = CODE_IN[15:5];
  assign code_p = CODE_IN[4:0];

  // Recompute the four Hamming check bits from the received data.
  always_comb begin
    chk_bits[0] = code_d[0] ^ code_d[1] ^ code_d[3] ^ code_d[4] ^ code_d[6] ^ code_d[8] ^ code_d[10];
    chk_bits[1] = code_d[0] ^ code_d[2] ^ code_d[3] ^ code_d[5] ^ code_d[6] ^ code_d[9] ^ code_d[10];
    chk_bits[2] = code_d[1] ^ code_d[2] ^ code_d[3] ^ code_d[7] ^ code_d[8] ^ code_d[9] ^ code_d[10];
    chk_bits[3] = code_d[4] ^ code_d[5] ^ code_d[6] ^ code_d[7] ^ code_d[8] ^ code_d[9] ^ code_d[10];
  end

  // Stage 1 next state: capture data, syndrome and overall parity on advance.
  always_comb begin
    v1_d  = v1_q;
    d1_d  = d1_q;
    s1_d  = s1_q;
    ov1_d = ov1_q;
    if (adv) begin
      v1_d  = in_valid;
      d1_d  = code_d;
      s1_d  = chk_bits ^ code_p[3:0];
      ov1_d = ^CODE_IN;
    end
  end

  // Map a syndrome to the data bit it points at; parity positions map to none.
  always_comb begin
    flip_mask = '0;
    case (s1_q)
      4'd3:    flip_mask[0]  = 1'b1;
      4'd5:    flip_mask[1]  = 1'b1;
      4'd6:    flip_mask[2]  = 1'b1;
      4'd7:    flip_mask[3]  = 1'b1;
      4'd9:    flip_mask[4]  = 1'b1;
      4'd10:   flip_mask[5]  = 1'b1;
      4'd11:   flip_mask[6]  = 1'b1;
      4'd12:   flip_mask[7]  = 1'b1;
      4'd13:   flip_mask[8]  = 1'b1;
      4'd14:   flip_mask[9]  = 1'b1;
      4'd15:   flip_mask[10] = 1'b1;
      default: flip_mask     = '0;
    endcase
  end

  // Stage 2 next state: odd overall parity means a single error (correctable),
  // even parity with a nonzero syndrome means a double error (data left raw).
  always_comb begin
    v2_d    = v2_q;
    data2_d = data2_q;
    sec2_d  = sec2_q;
    ded2_d  = ded2_q;
    syn2_d  = syn2_q;
    if (adv) begin
      v2_d    = v1_q;
      syn2_d  = s1_q;
      sec2_d  = v1_q && ov1_q;
      ded2_d  = v1_q && !ov1_q && (s1_q != 4'd0);
      data2_d = ov1_q ? (d1_q ^ flip_mask) : d1_q;
    end
  end

  // Error counters: clear wins over increment; increments saturate.
  always_comb begin
    sec_cnt_d = sec_cnt_q;
    ded_cnt_d = ded_cnt_q;
    if (cnt_clr) begin
      sec_cnt_d = '0;
      ded_cnt_d = '0;
    end else if (xfer) begin
      if (sec2_q && (sec_cnt_q != CntMax)) sec_cnt_d = sec_cnt_q + CNT_WIDTH'(1);
      if (ded2_q && (ded_cnt_q != CntMax)) ded_cnt_d = ded_cnt_q + CNT_WIDTH'(1);
    end
  end

  // All state, cleared asynchronously so in-flight words vanish on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      d1_q      <= '0;
      s1_q      <= '0;
      ov1_q     <= 1'b0;
      v2_q      <= 1'b0;
      data2_q   <= '0;
      sec2_q    <= 1'b0;
      ded2_q    <= 1'b0;
      syn2_q    <= '0;
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      v1_q      <= v1_d;
      d1_q      <= d1_d;
      s1_q      <= s1_d;
      ov1_q     <= ov1_d;
      v2_q      <= v2_d;
      data2_q   <= data2_d;
      sec2_q    <= sec2_d;
      ded2_q    <= ded2_d;
      syn2_q    <= syn2_d;
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
    end
  end

  assign out_valid = v2_q;
  assign DATA_OUT  = data2_q;
  assign sec       = sec2_q;
  assign ded       = ded2_q;
  assign syndrome  = syn2_q;
  assign sec_cnt   = sec_cnt_q;
  assign ded_cnt   = ded_cnt_q;

endmodule

// File: tb/tb_decode_h2_pipe.sv
// Bench for decode_h2_pipe: directed vectors with literal expectations plus a
// position-table Hamming model and scoreboard checked on every cycle.
module tb_decode_h2_pipe;

  localparam int unsigned CW = 2;
  localparam int MaxCnt = (1 << CW) - 1;
  // Hamming position of each data bit; parity bit j sits at position 2^j.
  localparam int Pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  typedef struct {
    logic [10:0] data;
    logic        sec;
    logic        ded;
    logic [3:0]  syn;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   CODE_IN = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [10:0]   DATA_OUT;
  logic          sec;
  logic          ded;
  logic [3:0]    syndrome;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] sec_cnt;
  logic [CW-1:0] ded_cnt;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  int   m_sec = 0;
  int   m_ded = 0;
  int   xfer_cnt = 0;

  decode_h2_pipe #(.CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .CODE_IN   (CODE_IN),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .DATA_OUT  (DATA_OUT),
    .sec       (sec),
    .ded       (ded),
    .syndrome  (syndrome),
    .cnt_clr   (cnt_clr),
    .sec_cnt   (sec_cnt),
    .ded_cnt   (ded_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Syndrome = XOR of the positions of all set bits; odd weight = single error.
  function automatic exp_t model(input logic [15:0] code);
    exp_t        e;
    logic [10:0] d;
    logic [3:0]  s;
    d = code[15:5];
    s = code[3:0];
    for (int i = 0; i < 11; i++) if (d[i]) s = s ^ 4'(Pos[i]);
    e.data = d;
    e.syn  = s;
    e.sec  = 1'b0;
    e.ded  = 1'b0;
    if (($countones(code) % 2) == 1) begin
      e.sec = 1'b1;
      for (int i = 0; i < 11; i++) if (Pos[i] == int'(s)) e.data[i] = ~d[i];
    end else if (s != 4'd0) begin
      e.ded = 1'b1;
    end
    return e;
  endfunction

  // Scoreboard / compare process.
  exp_t mon_e;
  logic mon_xfer;
  logic prev_stall = 1'b0;
  logic [10:0] prev_data;
  logic prev_sec, prev_ded;
  logic [3:0] prev_syn;
  int since_xfer = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_sec = 0;
      m_ded = 0;
      prev_stall = 1'b0;
      since_xfer = 0;
      chk("rst out_valid", 32'(out_valid), 0);
      chk("rst in_ready", 32'(in_ready), 1);
      chk("rst data", 32'(DATA_OUT), 0);
      chk("rst sec_cnt", 32'(sec_cnt), 0);
      chk("rst ded_cnt", 32'(ded_cnt), 0);
    end else begin
      chk("sec_cnt", 32'(sec_cnt), 32'(m_sec));
      chk("ded_cnt", 32'(ded_cnt), 32'(m_ded));
      chk("in_ready rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (prev_stall) begin
        chk("stall valid held", 32'(out_valid), 1);
        chk("stall data held", 32'(DATA_OUT), 32'(prev_data));
        chk("stall flags held", 32'({sec, ded, syndrome}), 32'({prev_sec, prev_ded, prev_syn}));
      end
      mon_xfer = out_valid && out_ready;
      if (out_valid) begin
        chk("sec/ded exclusive", 32'(sec && ded), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected output", 1, 0);
        end else begin
          mon_e = exp_q[0];
          chk("sb data", 32'(DATA_OUT), 32'(mon_e.data));
          chk("sb sec", 32'(sec), 32'(mon_e.sec));
          chk("sb ded", 32'(ded), 32'(mon_e.ded));
          chk("sb syndrome", 32'(syndrome), 32'(mon_e.syn));
        end
      end
      if (cnt_clr) begin
        m_sec = 0;
        m_ded = 0;
      end else if (mon_xfer && exp_q.size() != 0) begin
        if (mon_e.sec && m_sec < MaxCnt) m_sec++;
        if (mon_e.ded && m_ded < MaxCnt) m_ded++;
      end
      if (mon_xfer && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        xfer_cnt++;
      end
      if (exp_q.size() != 0 && !mon_xfer) begin
        since_xfer++;
        if (since_xfer == 30) chk("progress timeout", 0, 1);
      end else begin
        since_xfer = 0;
      end
      if (in_valid && in_ready) exp_q.push_back(model(CODE_IN));
      prev_stall = out_valid && !out_ready;
      prev_data  = DATA_OUT;
      prev_sec   = sec;
      prev_ded   = ded;
      prev_syn   = syndrome;
    end
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send_check(input logic [15:0] code, input logic [10:0] ed, input logic es,
                            input logic edd, input logic [3:0] esyn, input string nm);
    int n;
    CODE_IN  = code;
    in_valid = 1'b1;
    sync();
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, 32'(n + 1), 2);
    chk({nm, " data"}, 32'(DATA_OUT), 32'(ed));
    chk({nm, " sec"}, 32'(sec), 32'(es));
    chk({nm, " ded"}, 32'(ded), 32'(edd));
    chk({nm, " syndrome"}, 32'(syndrome), 32'(esyn));
    sync();
  endtask

  task automatic stream(input logic [15:0] w[$]);
    int   n;
    logic acc;
    foreach (w[k]) begin
      CODE_IN  = w[k];
      in_valid = 1'b1;
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 40) begin
        @(negedge clk);
        acc = in_ready;
        sync();
        n++;
      end
      if (!acc) chk("stream accept timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " drained"}, 32'(exp_q.size()), 0);
    repeat (2) @(negedge clk);
    sync();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] words[$];
    exp_t        pe;
    int          base;
    int          n;

    // Pin the model against hand-derived values.
    pe = model(16'hBC91);
    chk("model ded data", 32'(pe.data), 32'h5E4);
    chk("model ded syn", 32'({pe.sec, pe.ded, pe.syn}), 32'h18);
    pe = model(16'hBCB1);
    chk("model sec data", 32'(pe.data), 32'h5A5);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset in_ready", 32'(in_ready), 1);
    sync();
    rst = 1'b0;

    send_check(16'hB4B1, 11'h5A5, 1'b0, 1'b0, 4'h0, "clean");
    @(negedge clk);
    chk("clean cnts", 32'({sec_cnt, ded_cnt}), 0);
    sync();
    send_check(16'hBCB1, 11'h5A5, 1'b1, 1'b0, 4'hB, "sec_d6");
    @(negedge clk);
    chk("sec_d6 sec_cnt", 32'(sec_cnt), 1);
    sync();
    send_check(16'hB4A1, 11'h5A5, 1'b1, 1'b0, 4'h0, "sec_p4");
    send_check(16'hBC91, 11'h5E4, 1'b0, 1'b1, 4'h8, "ded");
    @(negedge clk);
    chk("ded ded_cnt", 32'(ded_cnt), 1);
    chk("ded sec_cnt", 32'(sec_cnt), 2);
    sync();
    send_check(16'hB4B0, 11'h5A5, 1'b1, 1'b0, 4'h1, "sec_p0");

    // Backpressure: stall the consumer for 3 cycles after the first output.
    base  = xfer_cnt;
    words = '{16'hB4B1, 16'hBCB1, 16'h0000, 16'hB4A1};
    fork
      stream(words);
      begin
        n = 0;
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        sync();
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall in_ready", 32'(in_ready), 0);
        end
        sync();
        out_ready = 1'b1;
      end
    join
    drain("backpressure");
    chk("backpressure count", 32'(xfer_cnt - base), 4);

    // Saturation of the 2-bit counter.
    cnt_clr = 1'b1;
    sync();
    cnt_clr = 1'b0;
    words = '{16'hBCB1, 16'hBCB1, 16'hBCB1, 16'hBCB1, 16'hBCB1};
    stream(words);
    drain("saturate");
    @(negedge clk);
    chk("sat sec_cnt", 32'(sec_cnt), 3);
    sync();

    // Clear coinciding with a sec transfer.
    CODE_IN  = 16'hBCB1;
    in_valid = 1'b1;
    sync();
    in_valid = 1'b0;
    sync();
    cnt_clr = 1'b1;
    @(negedge clk);
    chk("clr out_valid", 32'(out_valid), 1);
    sync();
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr wins sec_cnt", 32'(sec_cnt), 0);
    sync();

    // Reset with two words in flight.
    CODE_IN  = 16'hB4B1;
    in_valid = 1'b1;
    sync();
    CODE_IN = 16'hBCB1;
    sync();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(out_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    base = xfer_cnt;
    repeat (6) begin
      @(negedge clk);
      chk("post reset quiet", 32'(out_valid), 0);
    end
    chk("post reset no xfer", 32'(xfer_cnt - base), 0);
    sync();
    send_check(16'hB4B1, 11'h5A5, 1'b0, 1'b0, 4'h0, "cold restart");
    drain("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
